// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong constants and game state encoding
// Purpose: state encoding used by game_controller and the playfield
// geometry shared by the ball movement and graphics blocks.
package pong_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    typedef enum logic [1:0] {
        GS_IDLE  = ST_IDLE,
        GS_PLAY  = ST_PLAY,
        GS_PAUSE = ST_PAUSE,
        GS_OVER  = ST_OVER
    } game_state_t;

    localparam int BALL_SIZE     = 8;
    localparam int PADDLE_LENGTH = 64;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

endpackage

// File: rtl/game_controller_bcd2_sat_counter.sv
// rtl/game_controller_bcd2_sat_counter.sv - two-digit BCD counter saturating at 99
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset, clears count
//   clr    in   synchronous clear (wins over inc)
//   inc    in   add one; ignored once count is 8'h99
//   count  out  [7:4] tens, [3:0] units, always valid BCD
module bcd2_sat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'h00;
        end else if (clr) begin
            count <= 8'h00;
        end else if (inc && (count != 8'h99)) begin
            // 99 is excluded above, so tens never needs to wrap here
            if (count[3:0] == 4'd9) begin
                count <= {count[7:4] + 4'd1, 4'd0};
            end else begin
                count <= {count[7:4], count[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - pong rally score, lives and serve/pause/over sequencing
// Ports:
//   clk, reset         pixel clock; asynchronous active-high reset
//   endofframe         raw VGA end-of-display flag, synchronised here
//   collided, missed   level flags from ball movement
//   serve_btn          raw serve push button
//   hit_bcd            rally hits, two BCD digits
//   lives              remaining lives
//   state              00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   ball_hold          ball frozen at serve position
//   ball_reset         one-clock re-centre pulse
//   game_over          high while in OVER
module game_controller
    import pong_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       endofframe,
    input  logic       collided,
    input  logic       missed,
    input  logic       serve_btn,
    output logic [7:0] hit_bcd,
    output logic [1:0] lives,
    output logic [1:0] state,
    output logic       ball_hold,
    output logic       ball_reset,
    output logic       game_over
);

    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    // Two-flop synchronisers plus one edge register each
    logic [2:0] eof_sync;
    logic [2:0] srv_sync;
    logic       frame_tick;
    logic       serve_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eof_sync <= 3'b000;
            srv_sync <= 3'b000;
        end else begin
            eof_sync <= {eof_sync[1:0], endofframe};
            srv_sync <= {srv_sync[1:0], serve_btn};
        end
    end

    assign frame_tick  = eof_sync[1] & ~eof_sync[2];
    assign serve_press = srv_sync[1] & ~srv_sync[2];

    // Collision flags only count on the frame where they first appear
    logic prev_col;
    logic prev_mis;
    logic new_col;
    logic new_mis;

    assign new_col = collided & ~prev_col;
    assign new_mis = missed & ~prev_mis;

    game_state_t state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  pause_cnt_q, pause_cnt_d;
    logic        ball_reset_d;
    logic        hit_inc;
    logic        hit_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= GS_IDLE;
            lives_q     <= LIVES_INIT;
            pause_cnt_q <= 8'd0;
            prev_col    <= 1'b0;
            prev_mis    <= 1'b0;
            ball_reset  <= 1'b0;
            ball_hold   <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            pause_cnt_q <= pause_cnt_d;
            ball_reset  <= ball_reset_d;
            ball_hold   <= (state_d != GS_PLAY);
            game_over   <= (state_d == GS_OVER);
            if (frame_tick) begin
                prev_col <= collided;
                prev_mis <= missed;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        pause_cnt_d  = pause_cnt_q;
        ball_reset_d = 1'b0;
        hit_inc      = 1'b0;
        hit_clr      = 1'b0;
        case (state_q)
            GS_IDLE: begin
                if (serve_press) begin
                    state_d      = GS_PLAY;
                    ball_reset_d = 1'b1;
                end
            end
            GS_PLAY: begin
                if (frame_tick) begin
                    if (new_mis) begin
                        if (lives_q > 2'd1) begin
                            lives_d      = lives_q - 2'd1;
                            ball_reset_d = 1'b1;
                            pause_cnt_d  = 8'd0;
                            state_d      = GS_PAUSE;
                        end else begin
                            lives_d = 2'd0;
                            state_d = GS_OVER;
                        end
                    end else if (new_col) begin
                        hit_inc = 1'b1;
                    end
                end
            end
            GS_PAUSE: begin
                if (frame_tick) begin
                    if (pause_cnt_q == PAUSE_LAST) begin
                        state_d = GS_PLAY;
                    end else begin
                        pause_cnt_d = pause_cnt_q + 8'd1;
                    end
                end
            end
            GS_OVER: begin
                if (serve_press) begin
                    hit_clr = 1'b1;
                    lives_d = LIVES_INIT;
                    state_d = GS_IDLE;
                end
            end
            default: state_d = GS_IDLE;
        endcase
    end

    bcd2_sat_counter u_hits (
        .clk   (clk),
        .reset (reset),
        .clr   (hit_clr),
        .inc   (hit_inc),
        .count (hit_bcd)
    );

    assign lives = lives_q;
    assign state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - self-checking bench for game_controller
module tb_game_controller;

    localparam int PF = 60;
    localparam int SL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       endofframe = 1'b0;
    logic       collided = 1'b0;
    logic       missed = 1'b0;
    logic       serve_btn = 1'b0;
    logic [7:0] hit_bcd;
    logic [1:0] lives;
    logic [1:0] state;
    logic       ball_hold;
    logic       ball_reset;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int br_count = 0;
    bit done = 1'b0;

    game_controller #(.START_LIVES(SL), .PAUSE_FRAMES(PF)) dut (
        .clk        (clk),
        .reset      (reset),
        .endofframe (endofframe),
        .collided   (collided),
        .missed     (missed),
        .serve_btn  (serve_btn),
        .hit_bcd    (hit_bcd),
        .lives      (lives),
        .state      (state),
        .ball_hold  (ball_hold),
        .ball_reset (ball_reset),
        .game_over  (game_over)
    );

    always #20 clk = ~clk;

    // Reference model: game rules on plain integers, inputs seen through their
    // sampling history (a rise counts two edges after it is first sampled)
    int m_state = 0;
    int m_lives = SL;
    int m_hits  = 0;
    int m_pause = 0;
    bit m_br    = 1'b0;
    bit m_prevc = 1'b0;
    bit m_prevm = 1'b0;
    bit eh[3] = '{1'b0, 1'b0, 1'b0};
    bit sh[3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    always @(posedge clk) begin
        bit tick, press, nc, nm;
        if (reset) begin
            m_state = 0; m_lives = SL; m_hits = 0; m_pause = 0; m_br = 1'b0;
            m_prevc = 1'b0; m_prevm = 1'b0;
            eh = '{1'b0, 1'b0, 1'b0};
            sh = '{1'b0, 1'b0, 1'b0};
        end else begin
            tick  = eh[1] && !eh[2];
            press = sh[1] && !sh[2];
            nc = collided && !m_prevc;
            nm = missed && !m_prevm;
            m_br = 1'b0;
            case (m_state)
                0: if (press) begin m_state = 1; m_br = 1'b1; end
                1: if (tick) begin
                    if (nm) begin
                        if (m_lives > 1) begin
                            m_lives--; m_br = 1'b1; m_pause = 0; m_state = 2;
                        end else begin
                            m_lives = 0; m_state = 3;
                        end
                    end else if (nc && m_hits < 99) begin
                        m_hits++;
                    end
                end
                2: if (tick) begin
                    m_pause++;
                    if (m_pause == PF) m_state = 1;
                end
                default: if (press) begin m_hits = 0; m_lives = SL; m_state = 0; end
            endcase
            if (tick) begin
                m_prevc = collided;
                m_prevm = missed;
            end
            eh[2] = eh[1]; eh[1] = eh[0]; eh[0] = endofframe;
            sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = serve_btn;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!done) begin
            checks++;
            if (hit_bcd !== to_bcd(m_hits) || lives !== 2'(m_lives) ||
                state !== 2'(m_state) || ball_hold !== (m_state != 1) ||
                ball_reset !== m_br || game_over !== (m_state == 3)) begin
                errors++;
                $display("FAIL cycle t=%0t: dut hit=%h lives=%0d st=%0d hold=%b br=%b go=%b, model hit=%h lives=%0d st=%0d hold=%b br=%b go=%b",
                         $time, hit_bcd, lives, state, ball_hold, ball_reset, game_over,
                         to_bcd(m_hits), m_lives, m_state, m_state != 1, m_br, m_state == 3);
            end
            if (ball_reset) br_count++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic frame(input bit col, input bit mis, input bit srv);
        cyc();
        collided = col; missed = mis; serve_btn = srv; endofframe = 1'b1;
        cyc();
        serve_btn = 1'b0;
        repeat (3) cyc();
        endofframe = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic hit();
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic serve();
        cyc(); serve_btn = 1'b1;
        repeat (2) cyc();
        serve_btn = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic pause_frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) cyc();
        check("reset_state", state, 0);
        check("reset_lives", lives, SL);
        check("reset_hold", ball_hold, 1);
        reset = 1'b0;
        repeat (2) cyc();

        // serve then a rally with carry into tens
        serve();
        check("serve_state", state, 1);
        for (int i = 0; i < 9; i++) hit();
        check("hits_09", hit_bcd, 8'h09);
        hit();
        check("carry_10", hit_bcd, 8'h10);
        hit(); hit();
        check("hits_12", hit_bcd, 8'h12);
        check("play_state", state, 1);

        // collided held across five ticks scores once
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        check("held_col_once", hit_bcd, 8'h13);

        // climb to 98 then saturate
        for (int i = 0; i < 85; i++) hit();
        check("hits_98", hit_bcd, 8'h98);
        for (int i = 0; i < 3; i++) begin
            hit();
            check("sat_99", hit_bcd, 8'h99);
        end

        // simultaneous collide and miss: miss wins
        br_count = 0;
        frame(1'b1, 1'b1, 1'b0);
        check("miss_lives", lives, 2);
        check("miss_hits", hit_bcd, 8'h99);
        check("miss_state", state, 2);
        check("miss_br_width", br_count, 1);
        pause_frames(PF - 1);
        check("pause_59", state, 2);
        pause_frames(1);
        check("pause_60", state, 1);

        // reset mid-pause
        frame(1'b0, 1'b1, 1'b0);
        check("pause2_lives", lives, 1);
        pause_frames(30);
        reset = 1'b1;
        cyc();
        check("rst_state", state, 0);
        check("rst_hits", hit_bcd, 0);
        check("rst_lives", lives, SL);
        check("rst_hold", ball_hold, 1);
        check("rst_br", ball_reset, 0);
        check("rst_go", game_over, 0);
        cyc();
        reset = 1'b0; missed = 1'b0;
        repeat (2) cyc();

        // three misses to game over, then restart
        serve();
        frame(1'b0, 1'b1, 1'b0);
        check("m1_lives", lives, 2);
        pause_frames(PF);
        frame(1'b0, 1'b1, 1'b0);
        check("m2_lives", lives, 1);
        pause_frames(PF);
        frame(1'b0, 1'b1, 1'b0);
        check("m3_lives", lives, 0);
        check("m3_state", state, 3);
        check("m3_go", game_over, 1);
        serve();
        check("restart_state", state, 0);
        check("restart_hits", hit_bcd, 0);
        check("restart_lives", lives, SL);

        // randomised play
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                cyc(); reset = 1'b1;
                cyc(); reset = 1'b0;
            end
            frame(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0));
        end

        repeat (4) cyc();
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
